// File: rtl/core_mem_arbiter_pkg.sv
// Shared constants, types and index helper for the round-robin data-memory arbiter.
package core_mem_arbiter_pkg;

   localparam int unsigned NUM_CORES  = 4;
   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned CORE_IDX_W = $clog2(NUM_CORES);

   localparam logic [NUM_CORES-1:0] CORES_1 = 4'b0001;
   localparam logic [NUM_CORES-1:0] CORES_2 = 4'b0011;
   localparam logic [NUM_CORES-1:0] CORES_3 = 4'b0111;
   localparam logic [NUM_CORES-1:0] CORES_4 = 4'b1111;

   typedef logic [CORE_IDX_W-1:0] core_idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   // Core index 'step' positions after 'base', wrapping around the core ring.
   function automatic core_idx_t wrap_idx(input core_idx_t base, input int unsigned step);
      int unsigned sum;
      sum = 32'(base) + step;
      return core_idx_t'(sum % NUM_CORES);
   endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Core-array and shared-memory signal bundle seen by the arbiter.
interface core_mem_arbiter_if;
   import core_mem_arbiter_pkg::*;

   logic [NUM_CORES-1:0]        core_en;
   logic [NUM_CORES-1:0]        req;
   logic [NUM_CORES-1:0]        we;
   logic [NUM_CORES*ADDR_W-1:0] addr;
   logic [NUM_CORES*DATA_W-1:0] wdata;
   logic [NUM_CORES-1:0]        gnt;
   logic [NUM_CORES-1:0]        rvalid;
   logic [DATA_W-1:0]           rdata;
   logic                        mem_en;
   logic                        mem_we;
   logic [ADDR_W-1:0]           mem_addr;
   logic [DATA_W-1:0]           mem_wdata;
   logic [DATA_W-1:0]           mem_rdata;
   logic                        busy;

   modport slave (
      input  core_en, req, we, addr, wdata, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output core_en, req, we, addr, wdata, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
   );

endinterface

// File: rtl/core_mem_arbiter_rr_pick.sv
// Combinational round-robin pick: first active core after the last winner, wrapping.
module core_mem_arbiter_rr_pick
   import core_mem_arbiter_pkg::*;
(
   input  logic [NUM_CORES-1:0] act_i,
   input  core_idx_t            last_gnt_i,
   output core_idx_t            win_o,
   output logic                 valid_o
);

   core_idx_t cand_s;
   logic      hit_s;

   // Scan last_gnt+1 .. last_gnt+NUM_CORES; the first hit wins and later hits are masked.
   always_comb begin
      win_o   = last_gnt_i;
      valid_o = 1'b0;
      cand_s  = last_gnt_i;
      hit_s   = 1'b0;
      for (int unsigned k = 1; k <= NUM_CORES; k++) begin
         cand_s  = wrap_idx(last_gnt_i, k);
         hit_s   = act_i[cand_s] & ~valid_o;
         win_o   = hit_s ? cand_s : win_o;
         valid_o = valid_o | hit_s;
      end
   end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter for the shared single-port data memory: one access in flight,
// IDLE -> ISSUE -> (write) IDLE | (read) RESP -> IDLE, all outputs registered.
module core_mem_arbiter
   import core_mem_arbiter_pkg::*;
(
   input logic               clk,
   input logic               rst,
   core_mem_arbiter_if.slave bus
);

   arb_state_t           state_q, state_d;
   core_idx_t            last_gnt_q, last_gnt_d;
   core_idx_t            win_q, win_d, pick_win_s;
   logic                 pick_valid_s, load_s;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [NUM_CORES-1:0] act_s;
   logic [NUM_CORES-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic                 mem_en_q, mem_en_d, mem_we_q, mem_we_d, busy_q, busy_d;

   assign act_s  = bus.req & bus.core_en;
   assign load_s = (state_q == IDLE) && pick_valid_s;

   core_mem_arbiter_rr_pick u_pick (
      .act_i      (act_s),
      .last_gnt_i (last_gnt_q),
      .win_o      (pick_win_s),
      .valid_o    (pick_valid_s)
   );

   // Capture the winner's command on leaving IDLE; record the winner once it is issued.
   always_comb begin
      win_d      = win_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      last_gnt_d = last_gnt_q;
      if (load_s) begin
         win_d   = pick_win_s;
         we_d    = bus.we[pick_win_s];
         addr_d  = bus.addr[32'(pick_win_s)*ADDR_W +: ADDR_W];
         wdata_d = bus.wdata[32'(pick_win_s)*DATA_W +: DATA_W];
      end else begin
         win_d   = win_q;
      end
      if (state_q == ISSUE) begin
         last_gnt_d = win_q;
      end else begin
         last_gnt_d = last_gnt_q;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pick_valid_s) begin
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output values for the coming cycle, derived from the next state and next capture.
   always_comb begin
      gnt_d       = '0;
      rvalid_d    = '0;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      busy_d      = (state_d != IDLE);
      case (state_d)
         ISSUE: begin
            mem_en_d     = 1'b1;
            mem_we_d     = we_d;
            mem_addr_d   = addr_d;
            mem_wdata_d  = wdata_d;
            gnt_d[win_d] = 1'b1;
         end
         RESP: begin
            mem_en_d = 1'b0;
         end
         IDLE: begin
            if (state_q == RESP) begin
               rvalid_d[win_q] = 1'b1;
               rdata_d         = bus.mem_rdata;
            end else begin
               rdata_d         = rdata_q;
            end
         end
         default: begin
            mem_en_d = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture, priority pointer and output registers; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt_q  <= core_idx_t'(NUM_CORES - 1);
         win_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         gnt_q       <= '0;
         rvalid_q    <= '0;
         rdata_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         last_gnt_q  <= last_gnt_d;
         win_q       <= win_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         gnt_q       <= gnt_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;

endmodule
